sweep_sync_controller: RTL and testbench
========================================

Name: sweep_sync_controller

Overview:
- Controls the other end of the column flag/start handshake in the heat-diffusion grid.
- Collects the per-sweep completion flag from every build_column instance. Once all columns have finished, it drives a single one-cycle start pulse to all columns so the next time step begins in lockstep.
- Counts completed sweeps, supports run/pause, and can stop after a programmed number of iterations.
- Sits at grid top level, between the column array and the HPS/control registers.

Parameters:
- NUM_COLS, 16, number of columns in the grid; width of the flag vector.
- ITER_BITS, 16, width of the iteration counter and the iteration limit.
- GUARD, 8, cycles after a start pulse during which column flags are ignored.
- TIMEOUT_CYCLES, 65535, watchdog limit for one sweep (used only with SWEEP_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; 1 = allow sweeps to be released.
- max_iter  in  ITER_BITS  sweep limit; 0 = unlimited.
- col_flag  in  NUM_COLS  completion flag, one bit per column (bit i = column i).
- start  out  1  one-cycle pulse, fanned out to every column's start input.
- iter_count  out  ITER_BITS  number of completed sweeps.
- pending  out  NUM_COLS  columns not yet done in the current sweep (inverse of the sticky done bits).
- busy  out  1  high in COLLECT, PULSE and GUARD.
- done  out  1  high while in HALT.
- timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, start=0, iter_count=0, done_bits=0 (pending all ones), busy=0, done=0, timeout=0, guard and watchdog counters=0.
- All other logic is synchronous to posedge clk.
- Flag contract (decided):
  - A column's flag may remain high after a sweep.
  - The column must drop its flag within GUARD cycles of a start pulse.
  - Because of this, flags are sampled only in COLLECT.
  - done_bits is sticky: done_bits <= done_bits | col_flag on every cycle spent in COLLECT.
- States:
  - IDLE: waits for run=1, then goes to COLLECT. No start is issued, because the columns run their first sweep unprompted after reset.
  - COLLECT: accumulates done_bits. When (done_bits | col_flag) is all ones:
    - iter_count increments (wraps modulo 2^ITER_BITS).
    - If max_iter != 0 and the new count equals max_iter: go to HALT.
    - Else if run=1: go to PULSE.
    - Else: go to READY.
  - READY: all columns are parked and the sweep is counted. run=1 goes to PULSE.
  - PULSE: start=1 for exactly this cycle; done_bits cleared; guard counter loaded with GUARD-1; next state GUARD.
  - GUARD: flags ignored; counter decrements; at 0 go to COLLECT.
  - HALT: done=1. When run=0, done clears and the state goes to READY.
- Latency: the start pulse is asserted 2 cycles after the last missing flag rises, when run=1.
- Pause: run falling mid-sweep does not abort the sweep. The current sweep is counted, then the block parks in READY.
- Simultaneous flags on the completing cycle are OR'd in before the all-ones test.
- Column count: NUM_COLS=1 must work.
- Comparison: iter_count is compared against max_iter after the increment.
- Raising max_iter while in HALT has no effect until run toggles.
- Reset asserted mid-operation: returns to IDLE immediately; any in-flight start pulse is truncated.

Optional Feature:
- Macro: SWEEP_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to COLLECT and increments every cycle in COLLECT.
  - When it reaches TIMEOUT_CYCLES, timeout is set (sticky until reset) and the state goes to HALT without incrementing iter_count.
  - pending keeps its value so the stuck columns can be identified.
- When undefined: no watchdog logic is instantiated, timeout is tied to 0, and COLLECT waits indefinitely.

Test Plan:
- Basic release: NUM_COLS=4, run=1, max_iter=0; raise flags 0..3 staggered by 5 cycles -> iter_count=1, exactly one start pulse 2 cycles after the last flag, then 8 GUARD cycles.
- Sticky / level flags: flags held high continuously, each column drops its flag 3 cycles after start and re-raises it 20 cycles later -> exactly one start per sweep, no double count; iter_count increments by 1 per sweep.
- Limit: max_iter=3 -> after the 3rd completion done=1, no further start, iter_count=3; then run=0 -> done=0, state READY.
- Pause: deassert run mid-COLLECT -> sweep completes, iter_count increments, no start; reassert run -> start pulse the next cycle.
- Async reset: assert reset during PULSE -> start drops without waiting for a clock edge, iter_count=0, pending=4'hF.
- Timeout (with SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=100): column 2 never flags -> timeout=1 at COLLECT cycle 100, done=1, pending=4'b0100, iter_count unchanged.

Source files
------------

// File: rtl/sweep_sync_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sweep_sync_controller: collects per-column sweep-done flags and releases |
// | the next time step with one start pulse. Watchdog: SWEEP_TIMEOUT_EN.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sweep_sync_controller #(
  parameter int NUM_COLS       = 16,
  parameter int ITER_BITS      = 16,
  parameter int GUARD          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [ITER_BITS-1:0] max_iter,
  input  logic [NUM_COLS-1:0]  col_flag,
  output logic                 start,
  output logic [ITER_BITS-1:0] iter_count,
  output logic [NUM_COLS-1:0]  pending,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_READY   = 3'd2,
    S_PULSE   = 3'd3,
    S_GUARD   = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t                state;
  logic [NUM_COLS-1:0]   flag_q;
  logic [NUM_COLS-1:0]   done_bits;
  logic [NUM_COLS-1:0]   all_bits;
  logic [GW-1:0]         guard_cnt;
  logic [ITER_BITS-1:0]  iter_next;
  logic                  limit_hit;
  logic                  wd_trip;

  // Flags pass through one register stage, giving the two-cycle release latency.
  assign all_bits  = done_bits | flag_q;
  assign iter_next = iter_count + 1'b1;
  assign limit_hit = (max_iter != '0) && (iter_next == max_iter);
  assign pending   = ~done_bits;

`ifdef SWEEP_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT_CYCLES);

  logic [WW-1:0] wd_cnt;
  logic [WW-1:0] wd_next;
  logic          timeout_q;

  assign wd_next = wd_cnt + 1'b1;
  assign wd_trip = (state == S_COLLECT) && !(&all_bits) && (wd_next == WD_LIMIT);
  assign timeout = timeout_q;

  // Counter is held at zero outside COLLECT, so it restarts on every entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_COLLECT) ? wd_next : '0;
      if (wd_trip)
        timeout_q <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      start      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      iter_count <= '0;
      done_bits  <= '0;
      flag_q     <= '0;
      guard_cnt  <= '0;
    end else begin
      flag_q <= col_flag;
      start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_COLLECT;
            busy  <= 1'b1;
          end
        end
        S_COLLECT: begin
          done_bits <= all_bits;
          if (&all_bits) begin
            iter_count <= iter_next;
            if (limit_hit) begin
              state <= S_HALT;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (run) begin
              state <= S_PULSE;
              start <= 1'b1;
            end else begin
              state <= S_READY;
              busy  <= 1'b0;
            end
          end else if (wd_trip) begin
            state <= S_HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_READY: begin
          if (run) begin
            state <= S_PULSE;
            start <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_PULSE: begin
          done_bits <= '0;
          guard_cnt <= GUARD_LOAD;
          state     <= S_GUARD;
        end
        S_GUARD: begin
          if (guard_cnt == '0)
            state <= S_COLLECT;
          else
            guard_cnt <= guard_cnt - 1'b1;
        end
        S_HALT: begin
          if (!run) begin
            state <= S_READY;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sweep_sync_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sweep_sync_controller: randomized column emulation against a          |
// | timestamp-based reference model of the sweep handshake.                  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sweep_sync_controller;

  localparam int NC  = 4;
  localparam int IB  = 16;
  localparam int GRD = 8;
  localparam int TO  = 100;
`ifdef SWEEP_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  localparam int M_WAIT  = 0;
  localparam int M_SWEEP = 1;
  localparam int M_PARK  = 2;
  localparam int M_STOP  = 3;

  logic          clk;
  logic          reset;
  logic          run;
  logic [IB-1:0] max_iter;
  logic [NC-1:0] col_flag;
  logic          start;
  logic [IB-1:0] iter_count;
  logic [NC-1:0] pending;
  logic          busy;
  logic          done;
  logic          timeout;

  sweep_sync_controller #(
    .NUM_COLS(NC), .ITER_BITS(IB), .GUARD(GRD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .max_iter(max_iter), .col_flag(col_flag),
    .start(start), .iter_count(iter_count), .pending(pending), .busy(busy),
    .done(done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // Reference model: a sweep window opens at a given edge; flags seen at or
  // after that edge are noticed one edge later; a full set completes the sweep.
  int            m_mode;
  int            m_from;
  int            m_edges;
  logic [NC-1:0] m_seen;
  logic [NC-1:0] m_prev;
  logic [IB-1:0] m_count;
  bit            m_start;
  bit            m_timeout;
  bit            m_clear_next;

  int work_t[NC];
  int drop_t[NC];
  bit dead[NC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_WAIT; m_from = 0; m_edges = 0; m_seen = '0; m_prev = '0;
    m_count = '0; m_start = 1'b0; m_timeout = 1'b0; m_clear_next = 1'b0;
  endtask

  task automatic release_at(input int k);
    m_start = 1'b1;
    m_mode = M_SWEEP;
    m_from = k + GRD + 1;
    m_edges = 0;
    m_clear_next = 1'b1;
  endtask

  task automatic model_edge(input int k, input logic r, input logic [IB-1:0] mi,
                            input logic [NC-1:0] f);
    m_start = 1'b0;
    if (m_clear_next) begin
      m_seen = '0;
      m_clear_next = 1'b0;
    end
    case (m_mode)
      M_WAIT: if (r) begin m_mode = M_SWEEP; m_from = k; m_edges = 0; end
      M_SWEEP: begin
        if (k - 1 >= m_from) begin
          m_seen = m_seen | m_prev;
          m_edges++;
          if (m_seen == {NC{1'b1}}) begin
            m_count = m_count + 1'b1;
            if (mi != 0 && m_count == mi) m_mode = M_STOP;
            else if (r) release_at(k);
            else m_mode = M_PARK;
          end else if (TO_ON && m_edges == TO) begin
            m_timeout = 1'b1;
            m_mode = M_STOP;
          end
        end
      end
      M_PARK: if (r) release_at(k);
      default: if (!r) m_mode = M_PARK;
    endcase
    m_prev = f;
  endtask

  task automatic check_outputs();
    logic [NC-1:0] ep;
    ep = ~m_seen;
    chk("start", start, m_start);
    chk("iter_count", iter_count, m_count);
    chk("pending", pending, ep);
    chk("busy", busy, m_mode == M_SWEEP);
    chk("done", done, m_mode == M_STOP);
    chk("timeout", timeout, m_timeout);
  endtask

  task automatic cols_reset();
    col_flag = '0;
    for (int i = 0; i < NC; i++) begin
      work_t[i] = -1; drop_t[i] = -1; dead[i] = 1'b0;
    end
  endtask

  // Each column drops its flag 3 cycles after start and re-raises it ~20+ later.
  task automatic columns();
    for (int i = 0; i < NC; i++) begin
      if (drop_t[i] > 0) begin
        drop_t[i]--;
        if (drop_t[i] == 0) begin col_flag[i] = 1'b0; drop_t[i] = -1; end
      end
      if (work_t[i] > 0) begin
        work_t[i]--;
        if (work_t[i] == 0) begin
          if (!dead[i]) col_flag[i] = 1'b1;
          work_t[i] = -1;
        end
      end
      if (m_start) begin
        drop_t[i] = 3;
        work_t[i] = 23 + int'($urandom_range(0, 10));
      end
    end
  endtask

  task automatic tick();
    logic          r;
    logic [IB-1:0] mi;
    logic [NC-1:0] f;
    r = run; mi = max_iter; f = col_flag;
    @(posedge clk);
    cyc++;
    model_edge(cyc, r, mi, f);
    #1;
    check_outputs();
    columns();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cols_reset();
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    int b;
    reset = 1'b0; run = 1'b0; max_iter = '0; col_flag = '0;
    cols_reset();
    model_reset();

    // Reset state and idle hold with run low
    do_reset();
    repeat (5) tick();

    // Basic release with staggered first flags, then free-running sweeps
    for (int i = 0; i < NC; i++) work_t[i] = 5 * i + 1;
    run = 1'b1;
    repeat (250) tick();

    // Random pause/resume
    repeat (400) begin
      if ($urandom_range(0, 24) == 0) run = ~run;
      tick();
    end
    run = 1'b1;
    repeat (60) tick();

    // Iteration limit with simultaneous first flags
    do_reset();
    for (int i = 0; i < NC; i++) work_t[i] = 10;
    max_iter = 16'd3;
    run = 1'b1;
    b = 0;
    while (m_mode != M_STOP && b < 2000) begin tick(); b++; end
    if (b >= 2000) begin
      tests++; failed++;
      $error("FAIL limit_wait: observed no halt expected halt within %0d cycles", b);
    end
    repeat (20) tick();
    max_iter = 16'd10;
    repeat (10) tick();
    chk("halt_done", done, 1);
    chk("halt_iter", iter_count, 3);
    run = 1'b0;
    repeat (3) tick();
    chk("ready_done", done, 0);
    chk("ready_busy", busy, 0);
    max_iter = '0;
    run = 1'b1;
    repeat (80) tick();

    // Async reset landing in the pulse cycle
    b = 0;
    while (!m_start && b < 500) begin tick(); b++; end
    if (b >= 500) begin
      tests++; failed++;
      $error("FAIL pulse_wait: observed no start expected start within %0d cycles", b);
    end
    chk("pulse_high", start, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_start", start, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_pending", pending, 4'hF);
    chk("rst_busy", busy, 0);
    cols_reset();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // Column 2 never reports
    do_reset();
    dead[2] = 1'b1;
    for (int i = 0; i < NC; i++) work_t[i] = 2;
    run = 1'b1;
    repeat (130) tick();
`ifdef SWEEP_TIMEOUT_EN
    chk("to_flag", timeout, 1);
    chk("to_done", done, 1);
    chk("to_pending", pending, 4'b0100);
    chk("to_iter", iter_count, 0);
`else
    chk("nto_flag", timeout, 0);
    chk("nto_busy", busy, 1);
    chk("nto_pending", pending, 4'b0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
